// File: rtl/gas_alarm_controller_pkg.sv
// Shared codes for the gas alarm controller: FSM states, filtered level
// classes and fan speeds.
package gas_alarm_controller_pkg;

    localparam logic [1:0] ST_SAFE  = 2'd0;
    localparam logic [1:0] ST_WARN  = 2'd1;
    localparam logic [1:0] ST_ALARM = 2'd2;
    localparam logic [1:0] ST_VENT  = 2'd3;

    localparam logic [1:0] CLS_SAFE = 2'd0;
    localparam logic [1:0] CLS_WARN = 2'd1;
    localparam logic [1:0] CLS_HIGH = 2'd2;

    localparam logic [1:0] FAN_OFF  = 2'd0;
    localparam logic [1:0] FAN_LOW  = 2'd1;
    localparam logic [1:0] FAN_MED  = 2'd2;
    localparam logic [1:0] FAN_HIGH = 2'd3;

    function automatic logic [1:0] fan_for_state(input logic [1:0] st);
        case (st)
            ST_WARN:  return FAN_LOW;
            ST_ALARM: return FAN_HIGH;
            ST_VENT:  return FAN_MED;
            default:  return FAN_OFF;
        endcase
    endfunction

endpackage

// File: rtl/gas_alarm_controller_level_filter.sv
// Registers the sensor level, classifies it and only passes a class on once
// it has held for PERSIST_CYC consecutive cycles.
module gas_level_filter
    import gas_alarm_controller_pkg::*;
#(
    parameter int PERSIST_CYC = 4,
    parameter int WARN_LEVEL  = 3,
    parameter int ALARM_LEVEL = 5
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [2:0] gas_level,
    output logic [1:0] filt
);

    localparam int CW = $clog2(PERSIST_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(PERSIST_CYC);

    logic [2:0]    lvl_q;
    logic [1:0]    cls;
    logic [1:0]    cand;
    logic [1:0]    cand_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cls = CLS_SAFE;
        if (lvl_q >= 3'(ALARM_LEVEL)) begin
            cls = CLS_HIGH;
        end else if (lvl_q >= 3'(WARN_LEVEL)) begin
            cls = CLS_WARN;
        end

        cand_next = cand;
        cnt_next  = cnt;
        if (cls == cand) begin
            if (cnt != CNT_MAX) begin
                cnt_next = cnt + CW'(1);
            end
        end else begin
            cand_next = cls;
            cnt_next  = CW'(1);
        end
    end

    // filt follows on the same edge the count reaches its target, which keeps
    // the level-to-state latency at PERSIST_CYC+2 edges.
    always_ff @(posedge clk) begin
        if (!arst) begin
            lvl_q <= 3'd0;
            cand  <= CLS_SAFE;
            cnt   <= '0;
            filt  <= CLS_SAFE;
        end else begin
            lvl_q <= gas_level;
            cand  <= cand_next;
            cnt   <= cnt_next;
            if (cnt_next == CNT_MAX) begin
                filt <= cand_next;
            end
        end
    end

endmodule

// File: rtl/gas_alarm_controller.sv
// Gas alarm controller: filtered level drives a SAFE/WARN/ALARM/VENT FSM that
// commands fan, gas valve and buzzer; alarms latch until acknowledged.
module gas_alarm_controller
    import gas_alarm_controller_pkg::*;
#(
    parameter int PERSIST_CYC   = 4,
    parameter int VENT_HOLD_CYC = 16,
    parameter int BEEP_HALF     = 2,
    parameter int WARN_LEVEL    = 3,
    parameter int ALARM_LEVEL   = 5
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [2:0] gas_level,
    input  logic       ack,
    output logic [1:0] fan_speed,
    output logic       valve_close,
    output logic       buzzer,
    output logic       alarm_latched,
    output logic [1:0] state
);

    localparam int HW = $clog2(VENT_HOLD_CYC + 1);
    localparam int BW = $clog2(BEEP_HALF + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(VENT_HOLD_CYC - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_HALF - 1);

    logic [1:0]    filt;
    logic [1:0]    state_next;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_next;
    logic [BW-1:0] beep_cnt;

    gas_level_filter #(
        .PERSIST_CYC (PERSIST_CYC),
        .WARN_LEVEL  (WARN_LEVEL),
        .ALARM_LEVEL (ALARM_LEVEL)
    ) u_filter (
        .clk       (clk),
        .arst      (arst),
        .gas_level (gas_level),
        .filt      (filt)
    );

    always_comb begin
        state_next = state;
        hold_next  = hold;
        case (state)
            ST_SAFE: begin
                if (filt == CLS_HIGH)      state_next = ST_ALARM;
                else if (filt == CLS_WARN) state_next = ST_WARN;
            end
            ST_WARN: begin
                if (filt == CLS_HIGH)      state_next = ST_ALARM;
                else if (filt == CLS_SAFE) state_next = ST_SAFE;
            end
            ST_ALARM: begin
                if (ack && filt != CLS_HIGH) begin
                    state_next = ST_VENT;
                    hold_next  = HOLD_LOAD;
                end
            end
            default: begin
                // A returning HIGH level wins over both expiry and ack.
                if (filt == CLS_HIGH) begin
                    state_next = ST_ALARM;
                end else if (hold == '0) begin
                    state_next = (filt == CLS_WARN) ? ST_WARN : ST_SAFE;
                end else begin
                    hold_next = hold - HW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            state         <= ST_SAFE;
            hold          <= '0;
            beep_cnt      <= '0;
            fan_speed     <= FAN_OFF;
            valve_close   <= 1'b0;
            buzzer        <= 1'b0;
            alarm_latched <= 1'b0;
        end else begin
            state         <= state_next;
            hold          <= hold_next;
            fan_speed     <= fan_for_state(state_next);
            valve_close   <= (state_next == ST_ALARM) || (state_next == ST_VENT);
            alarm_latched <= (state_next == ST_ALARM);
            if (state_next != ST_ALARM) begin
                buzzer   <= 1'b0;
                beep_cnt <= '0;
            end else if (state != ST_ALARM) begin
                buzzer   <= 1'b1;
                beep_cnt <= '0;
            end else if (beep_cnt == BEEP_LAST) begin
                buzzer   <= ~buzzer;
                beep_cnt <= '0;
            end else begin
                beep_cnt <= beep_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_gas_alarm_controller.sv
// Directed bench for gas_alarm_controller at default parameters: reset,
// warn, glitch rejection, alarm/ack/vent, re-alarm from vent, reset mid-alarm.
module tb_gas_alarm_controller;

    logic       clk;
    logic       arst;
    logic [2:0] gas_level;
    logic       ack;
    logic [1:0] fan_speed;
    logic       valve_close;
    logic       buzzer;
    logic       alarm_latched;
    logic [1:0] state;

    int total;
    int bad;

    gas_alarm_controller dut (
        .clk           (clk),
        .arst          (arst),
        .gas_level     (gas_level),
        .ack           (ack),
        .fan_speed     (fan_speed),
        .valve_close   (valve_close),
        .buzzer        (buzzer),
        .alarm_latched (alarm_latched),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [1:0] fan,
                           input logic valve, input logic buz, input logic lat);
        chk({tag, ".state"},  {6'd0, state},         {6'd0, st});
        chk({tag, ".fan"},    {6'd0, fan_speed},     {6'd0, fan});
        chk({tag, ".valve"},  {7'd0, valve_close},   {7'd0, valve});
        chk({tag, ".buzzer"}, {7'd0, buzzer},        {7'd0, buz});
        chk({tag, ".latch"},  {7'd0, alarm_latched}, {7'd0, lat});
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset with a high level present.
        arst = 1'b0; gas_level = 3'd7; ack = 1'b0;
        tick(2);
        chk_all("reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        arst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("post_reset_hold", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_all("latency_alarm", 2'd2, 2'd3, 1'b1, 1'b1, 1'b1);

        // Clear back to a quiet filter.
        arst = 1'b0; gas_level = 3'd0;
        tick();
        arst = 1'b1;
        tick();
        chk_all("reset2", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Warn.
        gas_level = 3'd4;
        tick(5);
        chk_all("warn_pre", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("warn", 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        gas_level = 3'd0;
        tick(5);
        chk_all("warn_hold", 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("warn_to_safe", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Glitch shorter than the persistence window.
        gas_level = 3'd6;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) gas_level = 3'd0;
            tick();
            chk_all("glitch", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        end

        // Alarm, buzzer cadence, ignored ack, vent, expiry.
        gas_level = 3'd7;
        tick(5);
        chk_all("alarm_pre", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("alarm_enter", 2'd2, 2'd3, 1'b1, 1'b1, 1'b1);
        tick(); chk("beep1", {7'd0, buzzer}, 8'd1);
        tick(); chk("beep2", {7'd0, buzzer}, 8'd0);
        tick(); chk("beep3", {7'd0, buzzer}, 8'd0);
        tick(); chk("beep4", {7'd0, buzzer}, 8'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all("ack_ignored", 2'd2, 2'd3, 1'b1, 1'b1, 1'b1);
        gas_level = 3'd0;
        tick(6);
        chk("ack_not_remembered", {6'd0, state}, 8'd2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all("vent_enter", 2'd3, 2'd2, 1'b1, 1'b0, 1'b0);
        tick(14);
        chk("vent_mid", {6'd0, state}, 8'd3);
        tick();
        chk_all("vent_last", 2'd3, 2'd2, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("vent_expire", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Re-alarm from vent, then a full vent again.
        gas_level = 3'd7;
        tick(6);
        chk("realarm_a", {6'd0, state}, 8'd2);
        gas_level = 3'd0;
        tick(6);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("realarm_vent1", {6'd0, state}, 8'd3);
        gas_level = 3'd6;
        tick(5);
        chk_all("realarm_pre", 2'd3, 2'd2, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("realarm", 2'd2, 2'd3, 1'b1, 1'b1, 1'b1);
        gas_level = 3'd0;
        tick(6);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("vent2_enter", {6'd0, state}, 8'd3);
        tick(15);
        chk("vent2_last", {6'd0, state}, 8'd3);
        tick();
        chk_all("vent2_expire", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an alarm.
        gas_level = 3'd7;
        tick(6);
        chk("pre_reset_alarm", {6'd0, state}, 8'd2);
        arst = 1'b0; gas_level = 3'd0;
        tick();
        arst = 1'b1;
        chk_all("mid_reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("after_reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick(8);
        chk_all("after_reset_quiet", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
